// File: rtl/dmem_pkg.sv
// Shared types and byte-lane helpers for the data-memory responder.
// Stores are right-justified on the bus and get shifted up into their byte lanes here.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam logic [31:0] DMEM_BAD_READ = 32'hDEAD_BEEF;

    function automatic logic [3:0] lane_mask(input logic [3:0] mask, input logic [1:0] off);
        return mask << off;
    endfunction

    function automatic logic [31:0] lane_data(input logic [31:0] data, input logic [1:0] off);
        return data << {off, 3'b000};
    endfunction

endpackage

// File: rtl/dmem_sram.sv
// 1W1R word array with per-byte write enables and a registered read port.
// Each byte lane is a separate array; a read in the same cycle as a write returns the old data.
module dmem_sram #(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] rd_byte_reg;

            always_ff @(posedge clk) begin
                if (re) begin
                    rd_byte_reg <= mem[raddr];
                end
                if (we[gi]) begin
                    mem[waddr] <= wdata[8*gi +: 8];
                end
            end

            assign rdata[8*gi +: 8] = rd_byte_reg;
        end
    endgenerate

endmodule

// File: rtl/dmem_responder.sv
// Data-port responder: aligned byte-lane stores, loads returned after READ_LATENCY cycles
// with a one-cycle read_valid pulse, and a sticky flag for out-of-range accesses.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE    = 32'h8000_0000,
    parameter int          DEPTH_WORDS  = 4096,
    parameter int          READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic        write_enable,
    input  logic [3:0]  write_mask,
    input  logic        read_enable,
    output logic [31:0] read_data,
    output logic        read_valid,
    output logic        err
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [29:0] BASE_WORD = ADDR_BASE[31:2];
    localparam logic [29:0] DEPTH_W30 = 30'(DEPTH_WORDS);
    localparam logic [3:0]  LAT_M1    = 4'(READ_LATENCY - 1);

    dmem_state_t   state_reg, state_next;
    logic [3:0]    cnt_reg, cnt_next;
    logic [AW-1:0] idx_reg;
    logic [1:0]    off_reg;
    logic          ok_reg;
    logic [1:0]    rd_off_reg;
    logic          rd_bad_reg;
    logic          have_data_reg;
    logic          read_valid_reg;
    logic          err_reg;

    logic [29:0]   req_word;
    logic          req_ok;
    logic [1:0]    req_off;
    logic [AW-1:0] req_idx;
    logic          accept;
    logic          rd_fire;
    logic [AW-1:0] rd_idx;
    logic [1:0]    rd_off;
    logic          rd_ok;
    logic [3:0]    sram_we;
    logic [31:0]   sram_rdata;

    // Range decode of the live bus address, shared by stores and latency-1 loads.
    assign req_word = address[31:2] - BASE_WORD;
    assign req_ok   = (address[31:2] >= BASE_WORD) && (req_word < DEPTH_W30);
    assign req_off  = address[1:0];
    assign req_idx  = req_word[AW-1:0];

    assign sram_we = lane_mask(write_mask, req_off) & {4{write_enable & req_ok}};

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        accept     = 1'b0;
        rd_fire    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (read_enable) begin
                    accept   = 1'b1;
                    cnt_next = LAT_M1;
                    if (LAT_M1 == 4'd0) begin
                        state_next = RESP;
                        rd_fire    = 1'b1;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg == 4'd1) begin
                    state_next = RESP;
                    rd_fire    = 1'b1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // With latency 1 the array read happens on the accepting edge, so use the live address.
    assign rd_idx = (state_reg == IDLE) ? req_idx : idx_reg;
    assign rd_off = (state_reg == IDLE) ? req_off : off_reg;
    assign rd_ok  = (state_reg == IDLE) ? req_ok  : ok_reg;

    dmem_sram #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_sram (
        .clk   (clk),
        .we    (sram_we),
        .waddr (req_idx),
        .wdata (lane_data(write_data, req_off)),
        .re    (rd_fire & rd_ok),
        .raddr (rd_idx),
        .rdata (sram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            idx_reg        <= '0;
            off_reg        <= '0;
            ok_reg         <= 1'b0;
            rd_off_reg     <= '0;
            rd_bad_reg     <= 1'b0;
            have_data_reg  <= 1'b0;
            read_valid_reg <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            read_valid_reg <= (state_next == RESP);
            if (accept) begin
                idx_reg <= req_idx;
                off_reg <= req_off;
                ok_reg  <= req_ok;
            end
            if (rd_fire) begin
                rd_off_reg    <= rd_off;
                rd_bad_reg    <= !rd_ok;
                have_data_reg <= 1'b1;
            end
            if ((rd_fire && !rd_ok) || (write_enable && !req_ok)) begin
                err_reg <= 1'b1;
            end
        end
    end

    // Driven only from registers; the RAM output holds between reads so read_data holds too.
    assign read_data  = !have_data_reg ? 32'h0 :
                        rd_bad_reg     ? DMEM_BAD_READ :
                        (sram_rdata >> {rd_off_reg, 3'b000});
    assign read_valid = read_valid_reg;
    assign err        = err_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances at latencies 1, 2 and 3 share the store bus.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        write_enable;
    logic [3:0]  write_mask;
    logic        re1, re2, re3;
    logic [31:0] rd1, rd2, rd3;
    logic        v1, v2, v3;
    logic        e1, e2, e3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_responder #(.READ_LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .address(address), .write_data(write_data),
        .write_enable(write_enable), .write_mask(write_mask), .read_enable(re1),
        .read_data(rd1), .read_valid(v1), .err(e1)
    );
    dmem_responder #(.READ_LATENCY(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .address(address), .write_data(write_data),
        .write_enable(write_enable), .write_mask(write_mask), .read_enable(re2),
        .read_data(rd2), .read_valid(v2), .err(e2)
    );
    dmem_responder #(.READ_LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .address(address), .write_data(write_data),
        .write_enable(write_enable), .write_mask(write_mask), .read_enable(re3),
        .read_data(rd3), .read_valid(v3), .err(e3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic get_valid(input int which);
        case (which)
            1:       return v1;
            2:       return v2;
            default: return v3;
        endcase
    endfunction

    function automatic logic [31:0] get_data(input int which);
        case (which)
            1:       return rd1;
            2:       return rd2;
            default: return rd3;
        endcase
    endfunction

    task automatic set_re(input int which, input logic val);
        case (which)
            1:       re1 = val;
            2:       re2 = val;
            default: re3 = val;
        endcase
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
        address      = addr;
        write_data   = data;
        write_mask   = mask;
        write_enable = 1'b1;
        $display("store addr=%h data=%h mask=%b", addr, data, mask);
        tick();
        write_enable = 1'b0;
    endtask

    // Issues a load in the current cycle and reports the cycles until read_valid (-1 on timeout).
    task automatic run_load(input int which, input logic [31:0] addr, output int lat, output logic [31:0] data);
        address = addr;
        set_re(which, 1'b1);
        lat  = -1;
        data = 32'hx;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (get_valid(which)) begin
                lat  = c;
                data = get_data(which);
                break;
            end
        end
        set_re(which, 1'b0);
        $display("load dut%0d addr=%h latency=%0d data=%h", which, addr, lat, data);
    endtask

    task automatic test_reset();
        int pulses;
        int lat;
        logic [31:0] d;
        rst_n = 1'b0;
        tick();
        tick();
        total++; if ({v1, v2, v3} !== 3'b000) begin bad++; $display("FAIL reset_valid: got %b expected 000", {v1, v2, v3}); end
        total++; if ({rd1, rd2, rd3} !== 96'h0) begin bad++; $display("FAIL reset_data: got %h %h %h expected 0", rd1, rd2, rd3); end
        total++; if ({e1, e2, e3} !== 3'b000) begin bad++; $display("FAIL reset_err: got %b expected 000", {e1, e2, e3}); end
        rst_n = 1'b1;
        tick();
        address = 32'h8000_0010;
        re3 = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        total++; if (v3 !== 1'b0 || rd3 !== 32'h0) begin bad++; $display("FAIL reset_mid_wait: got valid=%b data=%h expected 0 0", v3, rd3); end
        re3 = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (v3) pulses++;
        end
        $display("reset mid-wait: pulses after release=%0d", pulses);
        total++; if (pulses != 0) begin bad++; $display("FAIL reset_discard: got %0d pulses expected 0", pulses); end
        run_load(3, 32'h8000_0010, lat, d);
        total++; if (lat != 3) begin bad++; $display("FAIL reset_idle_latency: got %0d expected 3", lat); end
        tick();
    endtask

    task automatic test_word();
        int lat;
        logic [31:0] d;
        do_store(32'h8000_0010, 32'h1234_5678, 4'b1111);
        run_load(2, 32'h8000_0010, lat, d);
        total++; if (lat != 2) begin bad++; $display("FAIL word_latency: got %0d expected 2", lat); end
        total++; if (d !== 32'h1234_5678) begin bad++; $display("FAIL word_data: got %h expected 12345678", d); end
        tick();
        total++; if (v2 !== 1'b0) begin bad++; $display("FAIL word_pulse_width: got %b expected 0", v2); end
        total++; if (rd2 !== 32'h1234_5678) begin bad++; $display("FAIL word_data_hold: got %h expected 12345678", rd2); end
    endtask

    task automatic test_byte_lanes();
        int lat;
        logic [31:0] d;
        do_store(32'h8000_0020, 32'hAABB_CCDD, 4'b1111);
        do_store(32'h8000_0022, 32'h0000_0011, 4'b0001);
        do_store(32'h8000_0024, 32'h0000_0000, 4'b1111);
        do_store(32'h8000_0026, 32'h0000_BEEF, 4'b0011);
        run_load(2, 32'h8000_0020, lat, d);
        tick();
        total++; if (d !== 32'hAA11_CCDD) begin bad++; $display("FAIL byte_store: got %h expected aa11ccdd", d); end
        run_load(2, 32'h8000_0023, lat, d);
        tick();
        total++; if (d !== 32'h0000_00AA) begin bad++; $display("FAIL byte_load_off3: got %h expected 000000aa", d); end
        run_load(2, 32'h8000_0024, lat, d);
        tick();
        total++; if (d !== 32'hBEEF_0000) begin bad++; $display("FAIL half_store: got %h expected beef0000", d); end
        run_load(2, 32'h8000_0026, lat, d);
        tick();
        total++; if (d !== 32'h0000_BEEF) begin bad++; $display("FAIL half_load_off2: got %h expected 0000beef", d); end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        address = 32'h8000_0010;
        re1 = 1'b1;
        $display("load dut1 back-to-back addr=80000010 then 80000020");
        tick();
        if (v1) pulses++;
        total++; if (v1 !== 1'b1 || rd1 !== 32'h1234_5678) begin bad++; $display("FAIL b2b_first: got valid=%b data=%h expected 1 12345678", v1, rd1); end
        address = 32'h8000_0020;
        tick();
        if (v1) pulses++;
        total++; if (v1 !== 1'b0) begin bad++; $display("FAIL b2b_gap: got %b expected 0", v1); end
        tick();
        if (v1) pulses++;
        total++; if (v1 !== 1'b1 || rd1 !== 32'hAA11_CCDD) begin bad++; $display("FAIL b2b_second: got valid=%b data=%h expected 1 aa11ccdd", v1, rd1); end
        re1 = 1'b0;
        tick();
        if (v1) pulses++;
        tick();
        if (v1) pulses++;
        total++; if (pulses != 2) begin bad++; $display("FAIL b2b_pulse_count: got %0d expected 2", pulses); end
    endtask

    task automatic test_hazard();
        int lat;
        logic [31:0] d;
        do_store(32'h8000_0040, 32'hCAFE_BABE, 4'b1111);
        run_load(1, 32'h8000_0040, lat, d);
        tick();
        total++; if (lat != 1 || d !== 32'hCAFE_BABE) begin bad++; $display("FAIL store_load_hazard: got lat=%0d data=%h expected 1 cafebabe", lat, d); end
        // Store on the same edge as the array read: the load sees the old word.
        address      = 32'h8000_0040;
        write_data   = 32'h1111_1111;
        write_mask   = 4'b1111;
        write_enable = 1'b1;
        re1          = 1'b1;
        tick();
        write_enable = 1'b0;
        re1          = 1'b0;
        $display("store+load same edge addr=80000040 data=%h", rd1);
        total++; if (v1 !== 1'b1 || rd1 !== 32'hCAFE_BABE) begin bad++; $display("FAIL read_before_write: got valid=%b data=%h expected 1 cafebabe", v1, rd1); end
        tick();
        run_load(1, 32'h8000_0040, lat, d);
        tick();
        total++; if (d !== 32'h1111_1111) begin bad++; $display("FAIL write_after_read: got %h expected 11111111", d); end
    endtask

    task automatic test_out_of_range();
        int lat;
        logic [31:0] d;
        total++; if (e1 !== 1'b0 || e2 !== 1'b0) begin bad++; $display("FAIL err_clear_before: got %b%b expected 00", e1, e2); end
        run_load(2, 32'h0000_0100, lat, d);
        total++; if (lat != 2 || d !== 32'hDEAD_BEEF) begin bad++; $display("FAIL oor_load: got lat=%0d data=%h expected 2 deadbeef", lat, d); end
        tick();
        total++; if (e2 !== 1'b1) begin bad++; $display("FAIL oor_load_err: got %b expected 1", e2); end
        total++; if (e1 !== 1'b0) begin bad++; $display("FAIL oor_err_isolated: got %b expected 0", e1); end
        do_store(32'h8000_3FFC, 32'h0BAD_F00D, 4'b1111);
        do_store(32'h8000_0000, 32'h00C0_FFEE, 4'b1111);
        do_store(32'h7FFF_FFFC, 32'h5555_5555, 4'b1111);
        do_store(32'h8000_4000, 32'h6666_6666, 4'b1111);
        total++; if (e1 !== 1'b1) begin bad++; $display("FAIL oor_store_err: got %b expected 1", e1); end
        run_load(2, 32'h8000_3FFC, lat, d);
        tick();
        total++; if (d !== 32'h0BAD_F00D) begin bad++; $display("FAIL top_word_intact: got %h expected 0badf00d", d); end
        run_load(2, 32'h8000_0000, lat, d);
        tick();
        total++; if (d !== 32'h00C0_FFEE) begin bad++; $display("FAIL base_word_intact: got %h expected 00c0ffee", d); end
        total++; if (e2 !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b expected 1", e2); end
    endtask

    initial begin
        rst_n        = 1'b0;
        address      = 32'h0;
        write_data   = 32'h0;
        write_enable = 1'b0;
        write_mask   = 4'b0000;
        re1          = 1'b0;
        re2          = 1'b0;
        re3          = 1'b0;
        test_reset();
        test_word();
        test_byte_lanes();
        test_back_to_back();
        test_hazard();
        test_out_of_range();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
